// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_queue
// Description : Collapsing, age-ordered reservation station feeding the
//               integer ALU; captures operands off the result broadcast bus.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_queue #(
    parameter int WIDTH  = 32,
    parameter int ALU_OP = 4,
    parameter int TAG_W  = 6,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [ALU_OP-1:0]        disp_op,
    input  logic [4:0]               disp_shamt,
    input  logic [TAG_W-1:0]         disp_dst_tag,
    input  logic                     disp_src1_rdy,
    input  logic [TAG_W-1:0]         disp_src1_tag,
    input  logic [WIDTH-1:0]         disp_src1_val,
    input  logic                     disp_src2_rdy,
    input  logic [TAG_W-1:0]         disp_src2_tag,
    input  logic [WIDTH-1:0]         disp_src2_val,
    input  logic                     wb_valid,
    input  logic [TAG_W-1:0]         wb_tag,
    input  logic [WIDTH-1:0]         wb_data,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [ALU_OP-1:0]        iss_op,
    output logic [WIDTH-1:0]         iss_rd1,
    output logic [WIDTH-1:0]         iss_rd2,
    output logic [4:0]               iss_shamt,
    output logic [TAG_W-1:0]         iss_dst_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_idx_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_idx_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    typedef struct packed {
        logic              valid;
        logic [ALU_OP-1:0] op;
        logic [4:0]        shamt;
        logic [TAG_W-1:0]  dst_tag;
        logic              s1_rdy;
        logic [TAG_W-1:0]  s1_tag;
        logic [WIDTH-1:0]  s1_val;
        logic              s2_rdy;
        logic [TAG_W-1:0]  s2_tag;
        logic [WIDTH-1:0]  s2_val;
    } entry_t;

    entry_t               r_q [DEPTH];
    logic [c_cnt_w-1:0]   r_count;

    entry_t               w_woke [DEPTH+1];
    entry_t               w_nxt  [DEPTH];
    entry_t               w_new;
    entry_t               w_sel_e;
    logic                 w_sel_found;
    logic [c_idx_w-1:0]   w_sel_idx;
    logic                 w_issue;
    logic                 w_disp_fire;
    logic [c_cnt_w-1:0]   w_wr_idx;
    logic [c_cnt_w-1:0]   w_cnt_nxt;

    // Capture a broadcast into any still-waiting source; ready sources keep their value.
    function automatic entry_t f_wake(input entry_t e, input logic v,
                                      input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] d);
        entry_t r;
        r = e;
        if (v && e.valid && !e.s1_rdy && e.s1_tag == t) begin
            r.s1_rdy = 1'b1;
            r.s1_val = d;
        end
        if (v && e.valid && !e.s2_rdy && e.s2_tag == t) begin
            r.s2_rdy = 1'b1;
            r.s2_val = d;
        end
        return r;
    endfunction

    // Oldest ready entry wins: scan from the top so the lowest index is kept last.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_q[i].valid && r_q[i].s1_rdy && r_q[i].s2_rdy) begin
                w_sel_found = 1'b1;
                w_sel_idx   = i[c_idx_w-1:0];
            end
        end
        w_sel_e = '0;
        if (w_sel_found) w_sel_e = r_q[w_sel_idx];
    end

    assign disp_ready  = (r_count < c_depth);
    assign w_issue     = w_sel_found && iss_ready;
    assign w_disp_fire = disp_valid && disp_ready;
    assign w_wr_idx    = r_count - c_cnt_w'(w_issue);
    assign w_cnt_nxt   = r_count + c_cnt_w'(w_disp_fire) - c_cnt_w'(w_issue);

    always_comb begin
        w_new         = '0;
        w_new.valid   = 1'b1;
        w_new.op      = disp_op;
        w_new.shamt   = disp_shamt;
        w_new.dst_tag = disp_dst_tag;
        w_new.s1_rdy  = disp_src1_rdy;
        w_new.s1_tag  = disp_src1_tag;
        w_new.s1_val  = disp_src1_val;
        w_new.s2_rdy  = disp_src2_rdy;
        w_new.s2_tag  = disp_src2_tag;
        w_new.s2_val  = disp_src2_val;
        w_new         = f_wake(w_new, wb_valid, wb_tag, wb_data);

        for (int i = 0; i < DEPTH; i++) begin
            w_woke[i] = f_wake(r_q[i], wb_valid, wb_tag, wb_data);
        end
        w_woke[DEPTH] = '0;

        // Entries above the issued slot collapse down by one.
        for (int i = 0; i < DEPTH; i++) begin
            if (w_issue && i >= int'(w_sel_idx)) w_nxt[i] = w_woke[i+1];
            else                                 w_nxt[i] = w_woke[i];
            if (w_disp_fire && i == int'(w_wr_idx)) w_nxt[i] = w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_q[i].valid <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            for (int i = 0; i < DEPTH; i++) r_q[i] <= w_nxt[i];
        end
    end

    assign iss_valid   = w_sel_found;
    assign iss_op      = w_sel_e.op;
    assign iss_rd1     = w_sel_e.s1_val;
    assign iss_rd2     = w_sel_e.s2_val;
    assign iss_shamt   = w_sel_e.shamt;
    assign iss_dst_tag = w_sel_e.dst_tag;
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_queue
// Description : Self-checking bench for alu_issue_queue (vector table plus
//               issue scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        disp_valid, disp_ready;
    logic [3:0]  disp_op;
    logic [4:0]  disp_shamt;
    logic [5:0]  disp_dst_tag;
    logic        disp_src1_rdy, disp_src2_rdy;
    logic [5:0]  disp_src1_tag, disp_src2_tag;
    logic [31:0] disp_src1_val, disp_src2_val;
    logic        wb_valid;
    logic [5:0]  wb_tag;
    logic [31:0] wb_data;
    logic        iss_valid, iss_ready;
    logic [3:0]  iss_op;
    logic [31:0] iss_rd1, iss_rd2;
    logic [4:0]  iss_shamt;
    logic [5:0]  iss_dst_tag;
    logic [3:0]  count;

    alu_issue_queue #(.WIDTH(32), .ALU_OP(4), .TAG_W(6), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_shamt(disp_shamt), .disp_dst_tag(disp_dst_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src1_tag(disp_src1_tag), .disp_src1_val(disp_src1_val),
        .disp_src2_rdy(disp_src2_rdy), .disp_src2_tag(disp_src2_tag), .disp_src2_val(disp_src2_val),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_rd1(iss_rd1), .iss_rd2(iss_rd2), .iss_shamt(iss_shamt),
        .iss_dst_tag(iss_dst_tag), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  shamt;
        logic [5:0]  dst;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } iss_t;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  shamt;
        logic [5:0]  dst;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
    } vec_t;

    iss_t sb[$];
    iss_t mon_act, mon_exp;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every accepted issue is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (iss_valid && iss_ready) begin
            checks++;
            mon_act = {iss_op, iss_shamt, iss_dst_tag, iss_rd1, iss_rd2};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue: unexpected op=%h dst=%h rd1=%h rd2=%h", iss_op, iss_dst_tag, iss_rd1, iss_rd2);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL issue: got op=%h sh=%h dst=%h rd1=%h rd2=%h, expected op=%h sh=%h dst=%h rd1=%h rd2=%h",
                             mon_act.op, mon_act.shamt, mon_act.dst, mon_act.rd1, mon_act.rd2,
                             mon_exp.op, mon_exp.shamt, mon_exp.dst, mon_exp.rd1, mon_exp.rd2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic no_disp();
        disp_valid = 1'b0; disp_op = '0; disp_shamt = '0; disp_dst_tag = '0;
        disp_src1_rdy = 1'b0; disp_src1_tag = '0; disp_src1_val = '0;
        disp_src2_rdy = 1'b0; disp_src2_tag = '0; disp_src2_val = '0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] sh, input logic [5:0] dst,
                         input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                         input logic r2, input logic [5:0] t2, input logic [31:0] v2);
        disp_valid = 1'b1; disp_op = op; disp_shamt = sh; disp_dst_tag = dst;
        disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
        disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
    endtask

    task automatic wb(input logic v, input logic [5:0] t, input logic [31:0] d);
        wb_valid = v; wb_tag = t; wb_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        vecs[0] = '{4'h0, 5'd0,  6'd1, 32'd5,        32'd7,        32'd5,        32'd7};
        vecs[1] = '{4'h1, 5'd3,  6'd2, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
        vecs[2] = '{4'h8, 5'd31, 6'd3, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};
        vecs[3] = '{4'hD, 5'd16, 6'd63, 32'h0,       32'h80000000, 32'h0,        32'h80000000};

        rst_n = 1'b0; flush = 1'b0; iss_ready = 1'b0;
        no_disp();
        wb(1'b0, '0, '0);

        // Reset state
        repeat (2) tick();
        settle();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_iss_valid", 64'(iss_valid), 64'd0);
        chk("reset_disp_ready", 64'(disp_ready), 64'd1);
        chk("reset_iss_data", {iss_op, iss_shamt, iss_dst_tag, iss_rd1[15:0]}, 64'd0);
        chk("reset_iss_rd2", 64'(iss_rd2), 64'd0);
        rst_n = 1'b1;
        tick();

        // Streamed table vectors: each cycle dispatches one op while the previous one issues.
        iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(vecs[k].op, vecs[k].shamt, vecs[k].dst, 1'b1, 6'd0, vecs[k].v1, 1'b1, 6'd0, vecs[k].v2);
            sb.push_back({vecs[k].op, vecs[k].shamt, vecs[k].dst, vecs[k].exp_rd1, vecs[k].exp_rd2});
            tick();
            settle();
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_iss_valid", 64'(iss_valid), 64'd1);
        end
        no_disp();
        tick();
        settle();
        chk("stream_drain_count", 64'(count), 64'd0);
        chk("stream_drain_valid", 64'(iss_valid), 64'd0);

        // Wakeup two cycles after dispatch; src1 already ready with the same tag must not be overwritten.
        drive(4'h1, 5'd0, 6'd10, 1'b1, 6'd9, 32'd100, 1'b0, 6'd9, 32'd0);
        tick();
        no_disp();
        settle();
        chk("wait_iss_valid", 64'(iss_valid), 64'd0);
        chk("wait_count", 64'(count), 64'd1);
        tick();
        wb(1'b1, 6'd9, 32'h20);
        sb.push_back({4'h1, 5'd0, 6'd10, 32'd100, 32'h20});
        settle();
        chk("wake_same_cycle_valid", 64'(iss_valid), 64'd0);
        tick();
        wb(1'b0, '0, '0);
        settle();
        chk("wake_next_valid", 64'(iss_valid), 64'd1);
        tick();
        settle();
        chk("wake_drain_count", 64'(count), 64'd0);

        // Broadcast in the dispatch cycle is captured through the bypass.
        drive(4'h2, 5'd4, 6'd11, 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'd1);
        wb(1'b1, 6'd3, 32'h0000ABCD);
        sb.push_back({4'h2, 5'd4, 6'd11, 32'h0000ABCD, 32'd1});
        tick();
        no_disp();
        wb(1'b0, '0, '0);
        settle();
        chk("bypass_iss_valid", 64'(iss_valid), 64'd1);
        tick();
        settle();
        chk("bypass_drain_count", 64'(count), 64'd0);

        // Fill all 8 entries; only entry 5 is ready.
        iss_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) drive(4'(i), 5'(i), 6'(20 + i), 1'b1, 6'd0, 32'h500, 1'b1, 6'd0, 32'(32'h100 + i));
            else        drive(4'(i), 5'(i), 6'(20 + i), 1'b0, 6'(40 + i), 32'd0, 1'b1, 6'd0, 32'(32'h100 + i));
            tick();
        end
        no_disp();
        settle();
        chk("full_count", 64'(count), 64'd8);
        chk("full_disp_ready", 64'(disp_ready), 64'd0);
        chk("full_iss_dst", 64'(iss_dst_tag), 64'd25);
        // Dispatch attempt while full and issuing: must be refused.
        drive(4'hF, 5'd0, 6'd60, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
        iss_ready = 1'b1;
        sb.push_back({4'h5, 5'd5, 6'd25, 32'h500, 32'h105});
        tick();
        no_disp();
        settle();
        chk("after_full_count", 64'(count), 64'd7);
        chk("after_full_disp_ready", 64'(disp_ready), 64'd1);
        // Wake the rest oldest-first; issues overlap with collapse and later wakeups.
        for (int j = 0; j < 8; j++) begin
            if (j != 5) begin
                wb(1'b1, 6'(40 + j), 32'(32'h1000 + j));
                sb.push_back({4'(j), 5'(j), 6'(20 + j), 32'(32'h1000 + j), 32'(32'h100 + j)});
                tick();
            end
        end
        wb(1'b0, '0, '0);
        tick();
        settle();
        chk("collapse_drain_count", 64'(count), 64'd0);

        // Stall with 4 ready entries, then flush with the handshake in the same cycle.
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(4'(3 + i), 5'd2, 6'(30 + i), 1'b1, 6'd0, 32'(32'hA0 + i), 1'b1, 6'd0, 32'(32'hB0 + i));
            tick();
        end
        no_disp();
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("stall_iss_valid", 64'(iss_valid), 64'd1);
            chk("stall_iss_fields", {iss_op, iss_dst_tag, iss_rd1[15:0], iss_rd2[15:0]},
                {4'h3, 6'd30, 16'h00A0, 16'h00B0});
            tick();
        end
        settle();
        chk("stall_count", 64'(count), 64'd4);
        flush = 1'b1;
        iss_ready = 1'b1;
        sb.push_back({4'h3, 5'd2, 6'd30, 32'hA0, 32'hB0});
        tick();
        flush = 1'b0;
        iss_ready = 1'b0;
        settle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_iss_valid", 64'(iss_valid), 64'd0);

        // Reset mid-operation discards the entry and the pending wakeup.
        drive(4'h4, 5'd0, 6'd12, 1'b0, 6'd50, 32'd0, 1'b1, 6'd0, 32'd9);
        tick();
        no_disp();
        rst_n = 1'b0;
        wb(1'b1, 6'd50, 32'd77);
        tick();
        rst_n = 1'b1;
        wb(1'b0, '0, '0);
        settle();
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_iss_valid", 64'(iss_valid), 64'd0);
        chk("midreset_disp_ready", 64'(disp_ready), 64'd1);
        tick();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
